// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side drain block.
//   state_e   : controller mode (idle, streaming, flushing)
//   BUF_DEPTH : entries in the output skid buffer
//   BUF_CNT_W : width of an occupancy count 0..BUF_DEPTH
package fifo_rd_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFlush
  } state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// Valid/ready stream carrying drained FIFO words with burst framing.
//   out_data  : word at the head of the stream
//   out_valid : out_data/out_last are meaningful
//   out_ready : sink accepts; transfer when out_valid && out_ready
//   out_last  : final word of a burst
// master = producer side (fifo_rd_drain), slave = consumer side.
interface fifo_rd_drain_if #(
  parameter int unsigned DATA_SIZE = 12
) ();

  logic [DATA_SIZE-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer holding {last, data} words between the FIFO pop and the stream.
//   rclk, rrst : clock, synchronous active-high reset (clears storage to zero)
//   push       : write wdata at the tail
//   pop        : drop the head entry
//   clear      : empty the buffer (wins over push/pop)
//   wdata      : entry to write
//   head       : oldest entry; only changes when the buffer was empty or on pop
//   count      : occupancy 0..BUF_DEPTH
module rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned Width = 13
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clear,
  input  logic [Width-1:0]     wdata,
  output logic [Width-1:0]     head,
  output logic [BUF_CNT_W-1:0] count
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);

  logic [Width-1:0]     mem_q [BUF_DEPTH];
  logic [PtrW-1:0]      rd_ptr_q;
  logic [PtrW-1:0]      wr_ptr;
  logic [BUF_CNT_W-1:0] count_q;

  // Depth is a power of two, so truncation gives the modulo wrap. When full, the tail
  // index aliases the head slot, which is only written together with a pop.
  assign wr_ptr = rd_ptr_q + PtrW'(count_q);
  assign head   = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr] <= wdata;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + BUF_CNT_W'(push) - BUF_CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-domain consumer for the async FIFO: pops first-word-fall-through words and presents
// them as a valid/ready stream through a 2-entry skid buffer, with burst framing, a flush
// mode that discards buffered and queued words, and delivered/dropped word counters.
//   rclk, rrst        : read clock, synchronous active-high reset
//   rEmpty, rData     : FIFO empty flag and head word
//   rinc              : FIFO pop strobe (combinational)
//   en                : streaming enable
//   flush_req         : discard buffer and FIFO contents
//   strm              : output stream (out_data/out_valid/out_ready/out_last)
//   flush_busy        : high while flushing
//   pop_count         : words delivered downstream (wrapping)
//   drop_count        : words discarded by flush (wrapping)
module fifo_rd_drain
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 12,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  input  logic                 en,
  input  logic                 flush_req,
  fifo_rd_drain_if.master      strm,
  output logic                 flush_busy,
  output logic [CNT_W-1:0]     pop_count,
  output logic [CNT_W-1:0]     drop_count
);

  localparam int unsigned BurstW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_e               state_q, state_d;
  logic [BurstW-1:0]    burst_q, burst_d;
  logic [CNT_W-1:0]     pop_q, pop_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [DATA_SIZE:0]   head;
  logic                 xfer;
  logic                 push;
  logic                 discard;
  logic                 burst_end;

  rd_skid_buf #(
    .Width(DATA_SIZE + 1)
  ) u_skid_buf (
    .rclk  (rclk),
    .rrst  (rrst),
    .push  (push),
    .pop   (xfer),
    .clear (flush_req),
    .wdata ({burst_end, rData}),
    .head  (head),
    .count (buf_cnt)
  );

  assign strm.out_valid = (buf_cnt != '0);
  assign strm.out_data  = head[DATA_SIZE-1:0];
  assign strm.out_last  = head[DATA_SIZE];
  assign xfer           = strm.out_valid && strm.out_ready;

  assign flush_busy = (state_q == StFlush);
  assign pop_count  = pop_q;
  assign drop_count = drop_q;
  assign burst_end  = (burst_q == BurstW'(BURST_LEN - 1));

  // A pop on the flush-entry edge is treated as a discard, not a capture.
  assign discard = flush_req || (state_q == StFlush);
  assign push    = rinc && (state_q == StStream) && !flush_req;

  always_comb begin
    rinc = 1'b0;
    unique case (state_q)
      StStream: rinc = !rEmpty && ((buf_cnt < BUF_CNT_W'(BUF_DEPTH)) || xfer);
      StFlush:  rinc = !rEmpty;
      default:  rinc = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (flush_req) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StIdle:   if (en) state_d = StStream;
        StStream: if (!en) state_d = StIdle;
        StFlush:  if (rEmpty) state_d = en ? StStream : StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (flush_req) begin
      burst_d = '0;
    end else if (push) begin
      burst_d = burst_end ? '0 : burst_q + BurstW'(1);
    end
  end

  always_comb begin
    pop_d  = pop_q + CNT_W'(xfer);
    drop_d = drop_q;
    // Words still buffered after this edge's transfer are lost on flush entry.
    if (flush_req) begin
      drop_d = drop_d + CNT_W'(buf_cnt) - CNT_W'(xfer);
    end
    if (rinc && discard) begin
      drop_d = drop_d + CNT_W'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= StIdle;
      burst_q <= '0;
      pop_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      pop_q   <= pop_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based FIFO environment plus a queue-level reference
// model of the drain (mode, output buffer, burst position, counters).
module tb_fifo_rd_drain;

  localparam int DW = 12;
  localparam int BL = 4;
  localparam int CW = 16;

  localparam int M_IDLE   = 0;
  localparam int M_STREAM = 1;
  localparam int M_FLUSH  = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  logic          rclk = 1'b0;
  logic          rrst;
  logic          rEmpty;
  logic [DW-1:0] rData;
  logic          rinc;
  logic          en;
  logic          flush_req;
  logic          flush_busy;
  logic [CW-1:0] pop_count;
  logic [CW-1:0] drop_count;

  fifo_rd_drain_if #(.DATA_SIZE(DW)) strm ();

  fifo_rd_drain #(
    .DATA_SIZE(DW),
    .BURST_LEN(BL),
    .CNT_W    (CW)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rEmpty    (rEmpty),
    .rData     (rData),
    .rinc      (rinc),
    .en        (en),
    .flush_req (flush_req),
    .strm      (strm),
    .flush_busy(flush_busy),
    .pop_count (pop_count),
    .drop_count(drop_count)
  );

  always #5 rclk = ~rclk;

  // Environment FIFO (popped by the DUT's rinc) and the model's own copy of it.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] src_q[$];
  ent_t          mbuf[$];
  ent_t          xfers[$];
  int            mode;
  int            mburst;
  int            mpop;
  int            mdrop;
  int            checks;
  int            errors;

  function automatic void drive();
    rEmpty = (fifo_q.size() == 0);
    rData  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endfunction

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    src_q.push_back(w);
    drive();
  endtask

  function automatic logic m_rinc();
    if (mode == M_STREAM)
      return (src_q.size() > 0) &&
             ((mbuf.size() < 2) || (mbuf.size() > 0 && strm.out_ready === 1'b1));
    if (mode == M_FLUSH) return src_q.size() > 0;
    return 1'b0;
  endfunction

  // One clock cycle: sample, advance the model, let the edge happen, update the FIFO.
  task automatic step();
    logic          dut_rinc;
    logic          er;
    logic          was_empty;
    logic [DW-1:0] w;
    ent_t          e;
    #1;
    dut_rinc  = rinc;
    er        = m_rinc();
    was_empty = (src_q.size() == 0);
    if (!rrst && strm.out_valid === 1'b1 && strm.out_ready === 1'b1) begin
      e.d = strm.out_data;
      e.l = strm.out_last;
      xfers.push_back(e);
    end
    if (er) w = src_q.pop_front();
    else w = '0;
    if (rrst) begin
      mbuf.delete();
      mode = M_IDLE; mburst = 0; mpop = 0; mdrop = 0;
    end else begin
      if (mbuf.size() > 0 && strm.out_ready === 1'b1) begin
        void'(mbuf.pop_front());
        mpop++;
      end
      if (flush_req) begin
        mdrop += mbuf.size();
        mbuf.delete();
        mburst = 0;
        if (er) mdrop++;
        mode = M_FLUSH;
      end else begin
        if (er) begin
          if (mode == M_STREAM) begin
            e.d = w;
            e.l = (mburst == BL - 1);
            mbuf.push_back(e);
            mburst = (mburst + 1) % BL;
          end else begin
            mdrop++;
          end
        end
        case (mode)
          M_IDLE:   if (en) mode = M_STREAM;
          M_STREAM: if (!en) mode = M_IDLE;
          default:  if (was_empty) mode = en ? M_STREAM : M_IDLE;
        endcase
      end
    end
    @(posedge rclk);
    #1;
    if (dut_rinc === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive();
  endtask

  task automatic test_reset();
    rrst = 1'b1; en = 1'b1; flush_req = 1'b0; strm.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    step();
    step();
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", strm.out_valid); end
    checks++; if (pop_count !== '0) begin errors++; $display("FAIL reset_pop: got %0d want 0", pop_count); end
    checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", flush_busy); end
    rrst = 1'b0;
    step();
    #1;
    checks++; if (rinc !== 1'b1) begin errors++; $display("FAIL release_rinc: got %b want 1", rinc); end
  endtask

  task automatic test_streaming();
    int npop = 0, first_pop = -1, last_pop = -1, first_valid = -1;
    logic consec = 1'b1;
    strm.out_ready = 1'b1;
    xfers.delete();
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rinc === 1'b1) begin
        if (first_pop < 0) first_pop = c;
        else if (c != last_pop + 1) consec = 1'b0;
        last_pop = c;
        npop++;
      end
      if (strm.out_valid === 1'b1 && first_valid < 0) first_valid = c;
      step();
    end
    checks++; if (npop != 8 || !consec) begin errors++; $display("FAIL stream_pops: got %0d consec=%b want 8 consec=1", npop, consec); end
    checks++; if (first_valid != first_pop + 1) begin errors++; $display("FAIL stream_latency: got %0d want %0d", first_valid, first_pop + 1); end
    checks++; if (xfers.size() != 8) begin errors++; $display("FAIL stream_count: got %0d want 8", xfers.size()); end
    for (int i = 0; i < xfers.size() && i < 8; i++) begin
      checks++;
      if (xfers[i].d !== DW'(i + 1) || xfers[i].l !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL stream_word%0d: got %h/%b want %h/%b", i, xfers[i].d, xfers[i].l, i + 1, (i == 3 || i == 7));
      end
    end
    checks++; if (pop_count !== 16'd8) begin errors++; $display("FAIL stream_popcnt: got %0d want 8", pop_count); end
  endtask

  task automatic test_backpressure();
    int npop = 0;
    strm.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push_word(DW'(i));
    for (int c = 0; c < 6; c++) begin
      #1;
      if (rinc === 1'b1) npop++;
      step();
    end
    #1;
    checks++; if (npop != 2) begin errors++; $display("FAIL bp_pops: got %0d want 2", npop); end
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL bp_rinc: got %b want 0", rinc); end
    checks++; if (strm.out_valid !== 1'b1 || strm.out_data !== 12'h001) begin errors++; $display("FAIL bp_hold: got %b/%h want 1/001", strm.out_valid, strm.out_data); end
    strm.out_ready = 1'b1;
    xfers.delete();
    for (int c = 0; c < 10; c++) step();
    checks++; if (xfers.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", xfers.size()); end
    for (int i = 0; i < xfers.size() && i < 5; i++) begin
      checks++;
      if (xfers[i].d !== DW'(i + 1) || xfers[i].l !== (i == 3)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h/%b want %h/%b", i, xfers[i].d, xfers[i].l, i + 1, (i == 3));
      end
    end
  endtask

  task automatic test_flush();
    int pop_base, drop_base, npop = 0, busy_cycles = 0;
    strm.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DW'(12'h0A1 + i));
    for (int c = 0; c < 3; c++) step();
    pop_base  = mpop;
    drop_base = mdrop;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    #1;
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", strm.out_valid); end
    checks++; if (flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_on: got %b want 1", flush_busy); end
    for (int c = 0; c < 10; c++) begin
      #1;
      if (flush_busy !== 1'b1) break;
      busy_cycles++;
      if (rinc === 1'b1) npop++;
      step();
    end
    checks++; if (npop != 3) begin errors++; $display("FAIL flush_pops: got %0d want 3", npop); end
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL flush_busy_len: got %0d want 4", busy_cycles); end
    checks++; if (drop_count !== CW'(drop_base + 5)) begin errors++; $display("FAIL flush_drop: got %0d want %0d", drop_count, drop_base + 5); end
    checks++; if (pop_count !== CW'(pop_base)) begin errors++; $display("FAIL flush_pop: got %0d want %0d", pop_count, pop_base); end
  endtask

  task automatic test_enable();
    strm.out_ready = 1'b1;
    xfers.delete();
    for (int i = 0; i < 4; i++) push_word(DW'(12'h0B1 + i));
    step();
    en = 1'b0;
    step();
    #1;
    checks++; if (rinc !== 1'b0) begin errors++; $display("FAIL en_off_rinc: got %b want 0", rinc); end
    for (int c = 0; c < 3; c++) step();
    checks++; if (xfers.size() != 2) begin errors++; $display("FAIL en_off_drain: got %0d want 2", xfers.size()); end
    en = 1'b1;
    for (int c = 0; c < 6; c++) step();
    checks++; if (xfers.size() != 4) begin errors++; $display("FAIL en_count: got %0d want 4", xfers.size()); end
    for (int i = 0; i < xfers.size() && i < 4; i++) begin
      checks++;
      if (xfers[i].d !== DW'(12'h0B1 + i) || xfers[i].l !== (i == 3)) begin
        errors++;
        $display("FAIL en_word%0d: got %h/%b want %h/%b", i, xfers[i].d, xfers[i].l, 12'h0B1 + i, (i == 3));
      end
    end
  endtask

  task automatic test_empty();
    int bad_rinc = 0, bad_valid = 0;
    en = 1'b1;
    strm.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rinc !== 1'b0) bad_rinc++;
      if (strm.out_valid !== 1'b0) bad_valid++;
      step();
    end
    checks++; if (bad_rinc != 0) begin errors++; $display("FAIL empty_rinc: got %0d cycles high want 0", bad_rinc); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL empty_valid: got %0d cycles high want 0", bad_valid); end
    strm.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(DW'(12'h0C1 + i));
    for (int c = 0; c < 3; c++) step();
    #1;
    checks++; if (strm.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre: got %b want 1", strm.out_valid); end
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    #1;
    checks++; if (strm.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", strm.out_valid); end
    checks++; if (pop_count !== '0 || drop_count !== '0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", pop_count, drop_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en             = ($urandom_range(9) != 0);
      strm.out_ready = ($urandom_range(3) != 0);
      flush_req      = ($urandom_range(39) == 0);
      rrst           = ($urandom_range(299) == 0);
      if (fifo_q.size() < 12 && $urandom_range(1) == 1) push_word(DW'($urandom));
      #1;
      checks++; if (rinc !== m_rinc()) begin errors++; $display("FAIL rnd_rinc c%0d: got %b want %b", c, rinc, m_rinc()); end
      checks++; if (strm.out_valid !== (mbuf.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", c, strm.out_valid, mbuf.size() != 0); end
      if (mbuf.size() != 0) begin
        checks++;
        if (strm.out_data !== mbuf[0].d || strm.out_last !== mbuf[0].l) begin
          errors++;
          $display("FAIL rnd_head c%0d: got %h/%b want %h/%b", c, strm.out_data, strm.out_last, mbuf[0].d, mbuf[0].l);
        end
      end
      checks++; if (flush_busy !== (mode == M_FLUSH)) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", c, flush_busy, mode == M_FLUSH); end
      checks++; if (pop_count !== CW'(mpop)) begin errors++; $display("FAIL rnd_pop c%0d: got %0d want %0d", c, pop_count, CW'(mpop)); end
      checks++; if (drop_count !== CW'(mdrop)) begin errors++; $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_count, CW'(mdrop)); end
      step();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    mode = M_IDLE; mburst = 0; mpop = 0; mdrop = 0;
    rrst = 1'b1; en = 1'b0; flush_req = 1'b0; strm.out_ready = 1'b0;
    drive();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_enable();
    test_empty();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
